// File: rtl/dsp_bb_pkg.sv
// Shared DSP building-block helpers: constant log2 for pointer/counter widths
// and a width-parameterised signed clip reused by the saturating blocks.
package dsp_bb_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Clips v into the signed range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// DELAY-sample circular history for the comb stage; returns x[n-DELAY]
// combinationally (zero until primed) and tracks the fill state.
module sample_delay_line
  import dsp_bb_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int DELAY  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [IWIDTH-1:0] i_data,
  output logic signed [IWIDTH-1:0] o_old,
  output logic                     o_primed
);

  localparam int PW    = (DELAY > 1) ? clog2(DELAY) : 1;
  localparam int DEPTH = 1 << PW;
  localparam int CW    = clog2(DELAY + 1);
  localparam logic [PW-1:0] LAST = PW'(DELAY - 1);
  localparam logic [CW-1:0] FULL = CW'(DELAY);

  // Power-of-two depth keeps the pointer width matched to the index range.
  logic signed [IWIDTH-1:0] r_buf [DEPTH];
  logic [PW-1:0]            r_wptr;
  logic [CW-1:0]            r_cnt;
  logic                     r_primed;
  logic signed [IWIDTH-1:0] w_rd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr   <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (i_valid) begin
      r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (r_cnt != FULL) begin
        r_cnt    <= r_cnt + 1'b1;
        r_primed <= (r_cnt == FULL - 1'b1);
      end
    end
  end

  // History is never cleared; priming masks stale entries instead.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_valid) r_buf[r_wptr] <= i_data;
  end

  assign w_rd     = r_buf[r_wptr];
  assign o_old    = r_primed ? w_rd : '0;
  assign o_primed = r_primed;

endmodule

// File: rtl/signed_comb.sv
// Registered signed comb stage y[n] = x[n] - x[n-DELAY] with full bit growth.
// Define SIGNED_COMB_SAT_EN to clip the result back to IWIDTH and add o_sat.
module signed_comb
  import dsp_bb_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int DELAY  = 1,
`ifdef SIGNED_COMB_SAT_EN
  localparam int OWIDTH = IWIDTH
`else
  localparam int OWIDTH = IWIDTH + 1
`endif
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [IWIDTH-1:0] i_data,
  output logic                     o_valid,
  output logic signed [OWIDTH-1:0] o_data,
  output logic                     o_primed
`ifdef SIGNED_COMB_SAT_EN
  ,
  output logic                     o_sat
`endif
);

  logic signed [IWIDTH-1:0] w_old;
  logic signed [IWIDTH:0]   w_full;
  logic                     r_valid;
  logic signed [OWIDTH-1:0] r_data;

  sample_delay_line #(
    .IWIDTH(IWIDTH),
    .DELAY (DELAY)
  ) u_dly (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_old   (w_old),
    .o_primed(o_primed)
  );

  // One guard bit makes the difference exact for any operand pair.
  assign w_full = $signed({i_data[IWIDTH-1], i_data}) - $signed({w_old[IWIDTH-1], w_old});

`ifdef SIGNED_COMB_SAT_EN
  logic signed [63:0] w_ext;
  logic signed [63:0] w_sat;
  logic               r_sat;

  assign w_ext = 64'(w_full);
  assign w_sat = sat_signed(w_ext, IWIDTH);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_sat   <= i_valid && (w_sat != w_ext);
      if (i_valid) r_data <= w_sat[OWIDTH-1:0];
    end
  end

  assign o_sat = r_sat;
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_data <= w_full;
    end
  end
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: tb/tb_signed_comb.sv
// Bench for signed_comb: five instances (DELAY 1..5) share one stimulus stream
// and are checked against a sample-history model; honours SIGNED_COMB_SAT_EN.
module tb_signed_comb;

`ifdef SIGNED_COMB_SAT_EN
  localparam int  OW  = 16;
  localparam bit  SAT = 1'b1;
`else
  localparam int  OW  = 17;
  localparam bit  SAT = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 vin;
  logic signed [15:0]   din;
  logic                 dut_valid  [1:5];
  logic signed [OW-1:0] dut_data   [1:5];
  logic                 dut_primed [1:5];
  logic                 dut_sat    [1:5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 1; g <= 5; g++) begin : g_dut
    signed_comb #(
      .IWIDTH(16),
      .DELAY (g)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (vin),
      .i_data  (din),
      .o_valid (dut_valid[g]),
      .o_data  (dut_data[g]),
      .o_primed(dut_primed[g])
`ifdef SIGNED_COMB_SAT_EN
      ,
      .o_sat   (dut_sat[g])
`endif
    );
`ifndef SIGNED_COMB_SAT_EN
    assign dut_sat[g] = 1'b0;
`endif
  end

  int     n_pass = 0;
  int     n_total = 0;
  longint hist     [1:5][$];
  longint exp_data [1:5];
  bit     exp_valid;
  bit     exp_sat  [1:5];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit after it.
  task automatic step(input bit v, input longint d, input bit rn);
    longint old;
    longint full;
    longint clip;
    @(negedge clk);
    vin   = v;
    din   = 16'(d);
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      exp_valid = 1'b0;
      for (int g = 1; g <= 5; g++) begin
        hist[g].delete();
        exp_data[g] = 0;
        exp_sat[g]  = 1'b0;
      end
    end else begin
      exp_valid = v;
      for (int g = 1; g <= 5; g++) begin
        exp_sat[g] = 1'b0;
        if (v) begin
          old  = (hist[g].size() == g) ? hist[g][0] : 0;
          full = d - old;
          hist[g].push_back(d);
          if (hist[g].size() > g) void'(hist[g].pop_front());
          clip = full > 32767 ? 32767 : (full < -32768 ? -32768 : full);
          exp_data[g] = SAT ? clip : full;
          exp_sat[g]  = SAT && (clip != full);
        end
      end
    end
    #1;
    for (int g = 1; g <= 5; g++) begin
      chk($sformatf("valid_d%0d", g), 64'(dut_valid[g]), 64'(exp_valid));
      chk($sformatf("data_d%0d", g), 64'(dut_data[g]), exp_data[g]);
      chk($sformatf("primed_d%0d", g), 64'(dut_primed[g]),
          64'(hist[g].size() == g));
      chk($sformatf("sat_d%0d", g), 64'(dut_sat[g]), 64'(exp_sat[g]));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
  endtask

  initial begin
    int             ramp_exp [8];
    bit             vpat     [6];
    longint         dpat     [6];
    longint         cexp     [6];
    logic signed [15:0] r16;
    vin   = 1'b0;
    din   = '0;
    rst_n = 1'b0;
    ramp_exp = '{1, 2, 3, 4, 4, 4, 4, 4};
    vpat     = '{1, 0, 0, 1, 0, 1};
    dpat     = '{7, 1234, -999, 3, 555, 9};
    cexp     = '{7, 7, 7, 3, 3, 2};

    // Reset state
    do_reset();
    chk("rst_data", 64'(dut_data[3]), 0);
    chk("rst_primed", 64'(dut_primed[1]), 0);

    // First difference, DELAY=1
    step(1'b1, 10, 1'b1);
    chk("d1_first", 64'(dut_data[1]), 10);
    chk("d1_primed", 64'(dut_primed[1]), 1);
    step(1'b1, -5, 1'b1);
    chk("d1_second", 64'(dut_data[1]), -15);

    // Ramp, DELAY=4
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i + 1, 1'b1);
      chk("ramp_d4", 64'(dut_data[4]), ramp_exp[i]);
      chk("ramp_d4_primed", 64'(dut_primed[4]), 64'(i >= 3));
    end

    // Gapped stream, DELAY=2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vpat[i], dpat[i], 1'b1);
      chk("gap_d2_data", 64'(dut_data[2]), cexp[i]);
      chk("gap_d2_valid", 64'(dut_valid[2]), 64'(vpat[i]));
    end

    // Extremes, DELAY=1
    do_reset();
    step(1'b1, -32768, 1'b1);
    step(1'b1, 32767, 1'b1);
    chk("ext_d1", 64'(dut_data[1]), SAT ? 32767 : 65535);
    chk("ext_d1_sat", 64'(dut_sat[1]), 64'(SAT));

    // Reset mid-stream with a colliding valid sample, DELAY=3
    do_reset();
    for (int i = 5; i <= 8; i++) step(1'b1, i, 1'b1);
    chk("mid_pre_d3", 64'(dut_data[3]), 3);
    step(1'b1, 99, 1'b0);
    chk("mid_rst_data", 64'(dut_data[3]), 0);
    chk("mid_rst_valid", 64'(dut_valid[3]), 0);
    chk("mid_rst_primed", 64'(dut_primed[3]), 0);
    step(1'b0, 0, 1'b1);
    chk("mid_hold", 64'(dut_data[3]), 0);
    step(1'b1, 9, 1'b1);
    chk("mid_after_d3", 64'(dut_data[3]), 9);
    chk("mid_after_primed", 64'(dut_primed[3]), 0);

    // Random soak with random gaps
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, longint'($urandom_range(0, 65535)) - 32768, 1'b1);
      r16 = 16'($urandom);
      step(1'b1, longint'(r16), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
